imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
//  Upstream of MIPS_top. Receives a program image as a byte stream (valid/ready), packs it
//  into 32-bit words and writes them to instruction memory from word 0. Holds the CPU in
//  reset until the image is loaded and its checksum matches, then releases it.
//  Replaces the fixed-image assumption for the single-cycle core.
// PARAMETERS
//  ADDR_W     8     imem word-address width; capacity MAX_WORDS = 2**ADDR_W
// PORTS
//  globalclock   in   1       system clock, rising edge
//  globalreset   in   1       asynchronous reset, active-low
//  in_valid      in   1       byte on in_byte is valid
//  in_byte       in   8       stream byte
//  in_ready      out  1       loader accepts byte this cycle (transfer = in_valid & in_ready)
//  reload        in   1       restart load from RUN or ERR (ignored in other states)
//  imem_we       out  1       one-cycle imem write strobe
//  imem_addr     out  ADDR_W  word address for write
//  imem_wdata    out  32      word to write
//  cpu_reset     out  1       active-high reset to MIPS_top globalreset
//  boot_done     out  1       image loaded and verified (high in RUN)
//  boot_err      out  1       length or checksum error (high in ERR, sticky)
//  words_loaded  out  ADDR_W+1  words written so far in current load
// BEHAVIOUR
//  Reset (globalreset=0, async): state=HDR_HI, in_ready=0 during reset, imem_we=0,
//   imem_addr=0, imem_wdata=0, cpu_reset=1, boot_done=0, boot_err=0, words_loaded=0,
//   csum=0, count=0, byte_idx=0.
//  Image format: CNT_HI, CNT_LO (16-bit word count N, big-endian), then N words of 4 bytes
//   each, MSB first, then 1 checksum byte = XOR of all preceding bytes incl. header.
//  States:
//   HDR_HI : in_ready=1; on transfer count[15:8]<=byte, csum<=byte -> HDR_LO.
//   HDR_LO : in_ready=1; on transfer count[7:0]<=byte; if full count > MAX_WORDS -> ERR;
//            if count==0 -> CSUM; else -> DATA.
//   DATA   : in_ready=1; on transfer shift byte into 32-bit pack reg, byte_idx++ (2-bit,
//            wraps); when 4th byte accepted -> WRITE.
//   WRITE  : in_ready=0; imem_we=1 for exactly this cycle with imem_addr=words_loaded[ADDR_W-1:0],
//            imem_wdata=packed word; words_loaded++ at end of cycle;
//            if words_loaded+1==count -> CSUM else -> DATA.
//   CSUM   : in_ready=1; on transfer: byte==csum -> RUN, else -> ERR.
//   RUN    : in_ready=0, cpu_reset=0, boot_done=1. reload=1 -> HDR_HI (cpu_reset=1 next cycle,
//            boot_done=0, words_loaded/csum cleared).
//   ERR    : in_ready=0, cpu_reset=1, boot_err=1. reload=1 -> HDR_HI, boot_err cleared.
//  csum updated (XOR) on every accepted byte before CSUM state.
//  Write latency: imem_we asserts the cycle after the 4th byte of a word is accepted.
//  in_valid without in_ready: byte held by source, not consumed; no state change.
//  Bytes offered in RUN/ERR are not accepted. cpu_reset leaves 1 the cycle RUN is entered
//   (registered output, deasserts one clock after checksum byte accepted).
//  count==MAX_WORDS accepted; count==MAX_WORDS+1 -> ERR with zero writes.
//  Async reset mid-load aborts immediately: no further imem_we, cpu_reset=1, restart at HDR_HI.
// TESTING
//  1. N=2, words 0x20080005, 0x2009000A, correct csum -> 2 imem_we pulses addr 0,1 with those
//     data; cpu_reset falls 1 cycle after csum byte; boot_done=1, words_loaded=2.
//  2. Same image, csum byte XOR 0x01 -> boot_err=1, cpu_reset stays 1, boot_done=0.
//  3. Header 0x0000 + csum 0x00 -> no imem_we, RUN entered.
//  4. ADDR_W=8, header 0x0101 (257) -> ERR right after CNT_LO, no writes; reload -> HDR_HI.
//  5. in_valid toggled randomly (50%) over image of 16 words -> identical writes/addrs as
//     back-to-back; in_ready=0 in every WRITE cycle.
//  6. Assert globalreset=0 mid-word 3 of 8 -> outputs return to reset values asynchronously;
//     reload full image afterwards loads correctly from addr 0.

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// Byte-stream valid/ready channel that carries the program image into the boot loader.
// The source drives in_valid/in_byte and the loader answers with in_ready.
interface imem_boot_loader_if;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;

    modport master (output in_valid, output in_byte, input  in_ready);
    modport slave  (input  in_valid, input  in_byte, output in_ready);
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into instruction memory as 32-bit words
// and keeps the CPU in reset until the whole image has been written and verified.
module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic                globalclock,
    input  logic                globalreset,
    imem_boot_loader_if.slave   s_in,
    input  logic                reload,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [31:0]         imem_wdata,
    output logic                cpu_reset,
    output logic                boot_done,
    output logic                boot_err,
    output logic [ADDR_W:0]     words_loaded
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_RUN,
        ST_ERR
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_count;
    logic [7:0]          r_csum;
    logic [23:0]         r_pack;
    logic [1:0]          r_byte_idx;
    logic [ADDR_W:0]     r_words_loaded;
    logic                r_in_ready;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [31:0]         r_imem_wdata;
    logic                r_cpu_reset;
    logic                r_boot_done;
    logic                r_boot_err;

    logic                w_transfer;
    logic [15:0]         w_count_full;
    logic                w_last_word;
    logic                w_ready_next;

    assign w_transfer   = s_in.in_valid & r_in_ready;
    assign w_count_full = {r_count[15:8], s_in.in_byte};
    assign w_last_word  = (17'(r_words_loaded) + 17'd1) == {1'b0, r_count};
    // in_ready is registered from the next state so it is already low during reset and WRITE.
    assign w_ready_next = (w_next == ST_HDR_HI) || (w_next == ST_HDR_LO) ||
                          (w_next == ST_DATA)   || (w_next == ST_CSUM);

    always_ff @(posedge globalclock or negedge globalreset) begin
        if (!globalreset) begin
            r_state <= ST_HDR_HI;
        end else begin
            // NOTE: state is sequential, so it is updated with <= to avoid ordering races between processes.
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            ST_HDR_HI: if (w_transfer) w_next = ST_HDR_LO;
            ST_HDR_LO: begin
                if (w_transfer) begin
                    if ({1'b0, w_count_full} > MAX_WORDS) w_next = ST_ERR;
                    else if (w_count_full == 16'd0)       w_next = ST_CSUM;
                    else                                  w_next = ST_DATA;
                end
            end
            ST_DATA:   if (w_transfer && r_byte_idx == 2'd3) w_next = ST_WRITE;
            ST_WRITE:  w_next = w_last_word ? ST_CSUM : ST_DATA;
            ST_CSUM: begin
                if (w_transfer) w_next = (s_in.in_byte == r_csum) ? ST_RUN : ST_ERR;
            end
            ST_RUN,
            ST_ERR:    if (reload) w_next = ST_HDR_HI;
            default:   w_next = ST_HDR_HI;
        endcase
    end

    always_ff @(posedge globalclock or negedge globalreset) begin
        if (!globalreset) begin
            r_count        <= '0;
            r_csum         <= '0;
            r_pack         <= '0;
            r_byte_idx     <= '0;
            r_words_loaded <= '0;
            r_in_ready     <= 1'b0;
            r_imem_we      <= 1'b0;
            r_imem_addr    <= '0;
            r_imem_wdata   <= '0;
            r_cpu_reset    <= 1'b1;
            r_boot_done    <= 1'b0;
            r_boot_err     <= 1'b0;
        end else begin
            r_in_ready  <= w_ready_next;
            r_cpu_reset <= (w_next != ST_RUN);
            r_boot_done <= (w_next == ST_RUN);
            r_boot_err  <= (w_next == ST_ERR);
            r_imem_we   <= 1'b0;

            // Checksum covers header and data; the first header byte restarts it.
            if (w_transfer && r_state != ST_CSUM) begin
                r_csum <= (r_state == ST_HDR_HI) ? s_in.in_byte : (r_csum ^ s_in.in_byte);
            end

            case (r_state)
                ST_HDR_HI: if (w_transfer) r_count[15:8] <= s_in.in_byte;
                ST_HDR_LO: if (w_transfer) r_count[7:0]  <= s_in.in_byte;
                ST_DATA: begin
                    if (w_transfer) begin
                        r_pack     <= {r_pack[15:0], s_in.in_byte};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= r_words_loaded[ADDR_W-1:0];
                            r_imem_wdata <= {r_pack, s_in.in_byte};
                        end
                    end
                end
                ST_WRITE:  r_words_loaded <= r_words_loaded + 1'b1;
                ST_RUN,
                ST_ERR: begin
                    if (reload) begin
                        r_words_loaded <= '0;
                        r_csum         <= '0;
                        r_count        <= '0;
                        r_byte_idx     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_in.in_ready = r_in_ready;
    assign imem_we       = r_imem_we;
    assign imem_addr     = r_imem_addr;
    assign imem_wdata    = r_imem_wdata;
    assign cpu_reset     = r_cpu_reset;
    assign boot_done     = r_boot_done;
    assign boot_err      = r_boot_err;
    assign words_loaded  = r_words_loaded;

endmodule
